result_accumulator: RTL and testbench

- Downstream stage of the adder wrapper. Consumes adder results over a valid/ready handshake.
- Sums BURST consecutive results into a wider accumulator, then presents the total on an output valid/ready handshake.
- Sits between the adder block's output interface and the result sink or scoreboard.
- Gives the bench a second sequential stage with independent backpressure.

---
 rtl/result_acc_if.sv | 37 +++
 rtl/result_accumulator.sv | 101 ++++++++++
 tb/tb_result_accumulator.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/result_acc_if.sv
// Handshake bundle between the adder output, the result accumulator and its sink.
// The flush request exists only when RESULT_ACC_FLUSH_EN is defined.
interface result_acc_if #(
    parameter int WIDTH     = 32,
    parameter int BURST     = 4,
    parameter int ACC_WIDTH = WIDTH + $clog2(BURST) + 1,
    parameter int CNT_W     = $clog2(BURST + 1)
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic [CNT_W-1:0]     out_count;
`ifdef RESULT_ACC_FLUSH_EN
    logic                 flush;
`endif

    // master: the environment (result producer and sum consumer)
    modport master (
        output in_valid, in_data, out_ready,
`ifdef RESULT_ACC_FLUSH_EN
        output flush,
`endif
        input  in_ready, out_valid, out_data, out_count
    );

    // slave: the accumulator itself
    modport slave (
        input  in_valid, in_data, out_ready,
`ifdef RESULT_ACC_FLUSH_EN
        input  flush,
`endif
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/result_accumulator.sv
// Sums BURST consecutive unsigned adder results and emits the total over valid/ready.
// Defining RESULT_ACC_FLUSH_EN adds a flush input that emits a partial burst early.
module result_accumulator #(
    parameter int WIDTH     = 32,
    parameter int BURST     = 4,
    parameter int ACC_WIDTH = WIDTH + $clog2(BURST) + 1
) (
    input  logic           clk,
    input  logic           rst,
    result_acc_if.slave    bus
);
    localparam int CNT_W = $clog2(BURST + 1);

    localparam logic [1:0] INIT  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;

    logic [1:0]           state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     cnt;
    logic                 in_ready;
    logic                 out_valid;
    logic [ACC_WIDTH-1:0] out_data;
    logic [CNT_W-1:0]     out_count;

    logic                 beat;
    logic                 emit;
    logic [ACC_WIDTH-1:0] sum;
    logic [CNT_W-1:0]     emit_count;

    // Zero-extends (or truncates, for a narrowed ACC_WIDTH) and wraps modulo 2^ACC_WIDTH.
    function automatic logic [ACC_WIDTH-1:0] acc_add(
        input logic [ACC_WIDTH-1:0] base,
        input logic [WIDTH-1:0]     data,
        input logic                 en
    );
        return base + (en ? ACC_WIDTH'(data) : '0);
    endfunction

    always_comb begin
        beat       = bus.in_valid && in_ready;
        sum        = acc_add(acc, bus.in_data, beat);
        emit_count = cnt + CNT_W'(beat);
        emit       = beat && (cnt == CNT_W'(BURST - 1));
`ifdef RESULT_ACC_FLUSH_EN
        // A flush with nothing accumulated and no beat this cycle has nothing to send.
        if (bus.flush && (cnt != '0 || beat))
            emit = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            case (state)
                INIT: begin
                    in_ready <= 1'b1;
                    state    <= ACCUM;
                end
                ACCUM: begin
                    if (emit) begin
                        out_data  <= sum;
                        out_count <= emit_count;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        state     <= SEND;
                    end else if (beat) begin
                        acc <= sum;
                        cnt <= cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= INIT;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_count = out_count;
endmodule

// File: tb/tb_result_accumulator.sv
// Directed bench for result_accumulator (WIDTH=8, BURST=4); flush steps run only
// when RESULT_ACC_FLUSH_EN is defined.
module tb_result_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    result_acc_if #(.WIDTH(8), .BURST(4)) bus ();

    result_accumulator #(.WIDTH(8), .BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and holds it until accepted (bounded).
    task automatic put(input logic [7:0] d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.in_ready) check("put_timeout", 32'(n), 32'd0);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Waits for a sum, checks it, takes it, and checks in_ready returns next cycle.
    task automatic get(input string tag, input logic [31:0] d, input logic [31:0] c);
        int n = 0;
        bus.out_ready = 1'b1;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_data"}, 32'(bus.out_data), d);
        check({tag, "_count"}, 32'(bus.out_count), c);
        tick();
        check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
`ifdef RESULT_ACC_FLUSH_EN
        bus.flush     = 1'b0;
`endif
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_count", 32'(bus.out_count), 32'd0);
        tick();
        tick();
        check("rst_hold_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        check("init_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("accum_in_ready", 32'(bus.in_ready), 32'd1);

        // Basic back-to-back burst
        put(8'd10); put(8'd20); put(8'd30); put(8'd40);
        get("b2b", 32'd100, 32'd4);

        // Maximum inputs, then a small burst to show the accumulator was cleared
        put(8'd255); put(8'd255); put(8'd255); put(8'd255);
        get("max", 32'd1020, 32'd4);
        put(8'd1); put(8'd1); put(8'd1); put(8'd1);
        get("clear", 32'd4, 32'd4);

        // Backpressure: sum must hold while upstream keeps offering data
        bus.out_ready = 1'b0;
        put(8'd1); put(8'd2); put(8'd3); put(8'd4);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd99;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_data", 32'(bus.out_data), 32'd10);
            check("bp_count", 32'(bus.out_count), 32'd4);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        get("bp", 32'd10, 32'd4);

        // Gapped input with in_valid toggling
        put(8'd5);
        tick(); tick();
        put(8'd6);
        tick();
        check("gap_no_early_out", 32'(bus.out_valid), 32'd0);
        put(8'd7); put(8'd8);
        get("gap", 32'd26, 32'd4);

        // Reset mid-burst drops the partial sum
        put(8'd3); put(8'd4);
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_data", 32'(bus.out_data), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        put(8'd1); put(8'd1); put(8'd1); put(8'd1);
        get("post_rst", 32'd4, 32'd4);

`ifdef RESULT_ACC_FLUSH_EN
        // Flush alone after two beats
        put(8'd5); put(8'd7);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        get("flush_alone", 32'd12, 32'd2);

        // Flush coinciding with the second beat includes that beat
        put(8'd1);
        bus.flush = 1'b1;
        put(8'd9);
        bus.flush = 1'b0;
        get("flush_beat", 32'd10, 32'd2);

        // Flush on an empty accumulator does nothing
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("flush_empty_no_out", 32'(bus.out_valid), 32'd0);
            check("flush_empty_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
        end
        put(8'd2); put(8'd2); put(8'd2); put(8'd2);
        get("flush_after", 32'd8, 32'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
